// File: rtl/mult_datapath.sv
// Shift-and-add multiplier datapath: accumulator, multiplicand and shift-counter
// registers driven by Load/Ad/Sh commands from an external controller.
module mult_datapath #(
  parameter int N = 16
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             Load,
  input  logic             Ad,
  input  logic             Sh,
  input  logic             Done,
  input  logic [N-1:0]     Mcand,
  input  logic [N-1:0]     Mplier,
  output logic             M,
  output logic             K,
  output logic [2*N-1:0]   Result,
  output logic             Valid
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [2*N:0]   acc;
  logic [N-1:0]   mcr;
  logic [CW-1:0]  cnt;

  // Load > Ad > Sh; a losing command has no effect at all, counter included
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      mcr <= '0;
      cnt <= '0;
    end else if (Load) begin
      acc <= {{(N + 1){1'b0}}, Mplier};
      mcr <= Mcand;
      cnt <= '0;
    end else if (Ad) begin
      acc[2*N:N] <= {1'b0, acc[2*N-1:N]} + {1'b0, mcr};
    end else if (Sh) begin
      acc <= {1'b0, acc[2*N:1]};
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Done samples the pre-update accumulator and wins over Load for Valid
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      Result <= '0;
      Valid  <= 1'b0;
    end else if (Done) begin
      Result <= acc[2*N-1:0];
      Valid  <= 1'b1;
    end else if (Load) begin
      Valid  <= 1'b0;
    end
  end

  assign M = acc[0];
  assign K = (cnt == CNT_LAST);

endmodule

// File: tb/tb_mult_datapath.sv
// Randomized bench for mult_datapath with an arithmetic reference model and
// literal checks of the known products and reset behaviour.
module tb_mult_datapath;
  localparam int N = 16;
  localparam longint unsigned MASK_N  = (64'd1 << N) - 1;
  localparam longint unsigned MASK_2N = (64'd1 << (2 * N)) - 1;

  logic           Clk = 1'b0;
  logic           reset, Load, Ad, Sh, Done;
  logic [N-1:0]   Mcand, Mplier;
  logic           M, K, Valid;
  logic [2*N-1:0] Result;

  int checks = 0;
  int errors = 0;

  longint unsigned m_acc, m_mcr, m_res;
  int              m_cnt;
  bit              m_val;

  mult_datapath #(.N(N)) dut (
    .Clk(Clk), .reset(reset), .Load(Load), .Ad(Ad), .Sh(Sh), .Done(Done),
    .Mcand(Mcand), .Mplier(Mplier), .M(M), .K(K), .Result(Result), .Valid(Valid)
  );

  always #5 Clk = ~Clk;

  // Reference model: accumulator as a plain number
  always @(posedge Clk or posedge reset) begin
    if (reset) begin
      m_acc = 0; m_mcr = 0; m_cnt = 0; m_res = 0; m_val = 0;
    end else begin
      if (Done) begin
        m_res = m_acc & MASK_2N;
        m_val = 1;
      end
      if (Load) begin
        m_acc = longint'(Mplier);
        m_mcr = longint'(Mcand);
        m_cnt = 0;
        if (!Done) m_val = 0;
      end else if (Ad) begin
        m_acc = ((((m_acc >> N) & MASK_N) + m_mcr) << N) | (m_acc & MASK_N);
      end else if (Sh) begin
        m_acc = m_acc >> 1;
        m_cnt = (m_cnt + 1) % N;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    chk("M_model", 64'(M), m_acc & 1);
    chk("K_model", 64'(K), 64'(m_cnt == N - 1));
    chk("Result_model", 64'(Result), m_res);
    chk("Valid_model", 64'(Valid), 64'(m_val));
  end

  // One clock cycle with the given commands; returns 1 time unit after the edge
  task automatic cyc(input bit l, input bit a, input bit s, input bit d,
                     input logic [N-1:0] mc, input logic [N-1:0] mp);
    @(negedge Clk);
    Load = l; Ad = a; Sh = s; Done = d; Mcand = mc; Mplier = mp;
    @(posedge Clk);
    #1;
    Load = 0; Ad = 0; Sh = 0; Done = 0;
  endtask

  task automatic run_mult(input logic [N-1:0] mc, input logic [N-1:0] mp, output int adds);
    adds = 0;
    cyc(1, 0, 0, 0, mc, mp);
    chk("Valid_after_load", 64'(Valid), 0);
    for (int i = 0; i < N; i++) begin
      if (m_acc[0]) begin
        cyc(0, 1, 0, 0, 0, 0);
        adds++;
      end
      chk("K_in_sh_cycle", 64'(K), 64'(i == N - 1));
      cyc(0, 0, 1, 0, 0, 0);
    end
    chk("K_wrapped", 64'(K), 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("product", 64'(Result), longint'(mc) * longint'(mp));
    chk("Valid_after_done", 64'(Valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    int adds;
    logic [N-1:0] a, b;
    reset = 1; Load = 0; Ad = 0; Sh = 0; Done = 0; Mcand = 0; Mplier = 0;
    #12;
    chk("rst_result", 64'(Result), 0);
    chk("rst_valid", 64'(Valid), 0);
    @(negedge Clk) reset = 0;
    repeat (3) cyc(0, 0, 0, 0, 16'hFFFF, 16'hFFFF);
    chk("idle_M", 64'(M), 0);
    chk("idle_K", 64'(K), 0);
    chk("idle_valid", 64'(Valid), 0);

    run_mult(16'd3, 16'd5, adds);
    chk("p3x5", 64'(Result), 64'h0000000F);

    // Done with Load: capture the old product, keep Valid
    cyc(1, 0, 0, 1, 16'd2, 16'd2);
    chk("done_load_result", 64'(Result), 64'd15);
    chk("done_load_valid", 64'(Valid), 1);
    for (int i = 0; i < N; i++) begin
      if (m_acc[0]) cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
    end
    cyc(0, 0, 0, 1, 0, 0);
    chk("p2x2", 64'(Result), 64'd4);

    run_mult(16'hFFFF, 16'hFFFF, adds);
    chk("pmax", 64'(Result), 64'hFFFE0001);

    run_mult(16'h1234, 16'h0000, adds);
    chk("pzero", 64'(Result), 0);
    chk("pzero_adds", 64'(adds), 0);

    // All three commands together: only Load takes effect
    cyc(1, 1, 1, 0, 16'hABCD, 16'h0001);
    chk("prio_M", 64'(M), 1);
    chk("prio_K", 64'(K), 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("prio_acc", 64'(Result), 64'h00000001);

    // Asynchronous reset after 7 shifts
    cyc(1, 0, 0, 0, 16'h00AB, 16'h0FFF);
    for (int i = 0; i < 7; i++) begin
      if (m_acc[0]) cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0);
    end
    cyc(0, 0, 0, 1, 0, 0);
    chk("pre_rst_valid", 64'(Valid), 1);
    @(posedge Clk);
    #3;
    reset = 1; Load = 1; Ad = 1; Sh = 1; Done = 1; Mplier = 16'hFFFF;
    #1;
    chk("async_result", 64'(Result), 0);
    chk("async_valid", 64'(Valid), 0);
    chk("async_M", 64'(M), 0);
    chk("async_K", 64'(K), 0);
    repeat (2) @(posedge Clk);
    #1;
    chk("held_result", 64'(Result), 0);
    chk("held_M", 64'(M), 0);
    @(negedge Clk);
    reset = 0; Load = 0; Ad = 0; Sh = 0; Done = 0;
    run_mult(16'h00AB, 16'h0FFF, adds);

    // Random operand multiplications
    for (int t = 0; t < 12; t++) begin
      a = N'($urandom);
      b = N'($urandom);
      run_mult(a, b, adds);
    end

    // Random command mixes against the model
    for (int t = 0; t < 400; t++) begin
      cyc(($urandom % 10) == 0, $urandom % 2, $urandom % 2, ($urandom % 5) == 0,
          N'($urandom), N'($urandom));
    end

    repeat (2) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
